// File: rtl/huffman_pkg.sv
// huffman_pkg: shared widths and FSM state encodings for the Huffman decoder
package huffman_pkg;
  localparam int CODE_W = 8;
  localparam int SYM_W  = 3;
  localparam int NSYM   = 6;
  localparam int LEN_W  = $clog2(CODE_W + 1);
  typedef enum logic [1:0] {ST_EMPTY, ST_RUN, ST_ERR} state_t;
endpackage

// File: rtl/huffman_if.sv
// huffman_if: code table, bitstream and symbol signals between a source (master) and the decoder (slave)
interface huffman_if;
  import huffman_pkg::*;
  logic              code_valid;
  logic [CODE_W-1:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [CODE_W-1:0] M1, M2, M3, M4, M5, M6;
  logic              flush;
  logic              bit_valid;
  logic              bit_in;
  logic              bit_ready;
  logic              sym_valid;
  logic [SYM_W-1:0]  sym;
  logic              err;
  modport master (
    output code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6, flush, bit_valid, bit_in,
    input  bit_ready, sym_valid, sym, err
  );
  modport slave (
    input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6, flush, bit_valid, bit_in,
    output bit_ready, sym_valid, sym, err
  );
endinterface

// File: rtl/huffman_match.sv
// huffman_match: finds the lowest-indexed table entry whose length and code equal the shifted accumulator
module huffman_match
  import huffman_pkg::*;
(
  input  logic [CODE_W-1:0] acc_n,
  input  logic [LEN_W-1:0]  len_n,
  input  logic [CODE_W-1:0] hc [NSYM],
  input  logic [CODE_W-1:0] m  [NSYM],
  output logic              hit,
  output logic [SYM_W-1:0]  idx
);
  logic [CODE_W-1:0] len_mask;
  always_comb begin
    len_mask = CODE_W'(({{CODE_W{1'b0}}, 1'b1} << len_n) - 1'b1);
    hit = 1'b0;
    idx = '0;
    // scan downwards so the lowest matching index is the one left standing
    for (int i = NSYM - 1; i >= 0; i--)
      if (m[i] == len_mask && (acc_n & m[i]) == hc[i]) begin
        hit = 1'b1;
        idx = SYM_W'(i + 1);
      end
  end
endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: latches a 6-entry code table and decodes an MSB-first bitstream into symbols 1..6
// HUFF_DEC_HIST_EN adds saturating per-symbol decode counters DCNT1..DCNT6.
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  huffman_if.slave bus
`ifdef HUFF_DEC_HIST_EN
  ,
  output logic [7:0] DCNT1,
  output logic [7:0] DCNT2,
  output logic [7:0] DCNT3,
  output logic [7:0] DCNT4,
  output logic [7:0] DCNT5,
  output logic [7:0] DCNT6
`endif
);
  state_t            state_q, state_d;
  logic [CODE_W-1:0] hc_q [NSYM], hc_d [NSYM], hc_in [NSYM];
  logic [CODE_W-1:0] m_q  [NSYM], m_d  [NSYM], m_in  [NSYM];
  logic [CODE_W-1:0] acc_q, acc_d, acc_n;
  logic [LEN_W-1:0]  len_q, len_d, len_n;
  logic              err_q, err_d, sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0]  sym_q, sym_d, idx;
  logic              hit, full;
`ifdef HUFF_DEC_HIST_EN
  logic [7:0]        dcnt_q [NSYM], dcnt_d [NSYM];
  assign {DCNT1, DCNT2, DCNT3, DCNT4, DCNT5, DCNT6} =
    {dcnt_q[0], dcnt_q[1], dcnt_q[2], dcnt_q[3], dcnt_q[4], dcnt_q[5]};
`endif
  assign hc_in = '{bus.HC1, bus.HC2, bus.HC3, bus.HC4, bus.HC5, bus.HC6};
  assign m_in  = '{bus.M1, bus.M2, bus.M3, bus.M4, bus.M5, bus.M6};
  assign acc_n = CODE_W'({acc_q, bus.bit_in});
  assign len_n = len_q + 1'b1;
  assign full  = len_n == LEN_W'(CODE_W);
  assign bus.bit_ready = state_q == ST_RUN;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym       = sym_q;
  assign bus.err       = err_q;
  huffman_match u_match (
    .acc_n (acc_n),
    .len_n (len_n),
    .hc    (hc_q),
    .m     (m_q),
    .hit   (hit),
    .idx   (idx)
  );
  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    m_d         = m_q;
    acc_d       = acc_q;
    len_d       = len_q;
    err_d       = err_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
`ifdef HUFF_DEC_HIST_EN
    dcnt_d      = dcnt_q;
`endif
    // priority: table load, then flush, then an accepted stream bit
    if (bus.code_valid) begin
      state_d = ST_RUN;
      hc_d    = hc_in;
      m_d     = m_in;
      acc_d   = '0;
      len_d   = '0;
      err_d   = 1'b0;
`ifdef HUFF_DEC_HIST_EN
      dcnt_d  = '{default: '0};
`endif
    end else if (bus.flush && state_q != ST_EMPTY) begin
      state_d = ST_RUN;
      acc_d   = '0;
      len_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == ST_RUN && bus.bit_valid) begin
      state_d     = (!hit && full) ? ST_ERR : ST_RUN;
      acc_d       = (hit || full) ? '0 : acc_n;
      len_d       = (hit || full) ? '0 : len_n;
      err_d       = !hit && full;
      sym_valid_d = hit;
      sym_d       = hit ? idx : sym_q;
`ifdef HUFF_DEC_HIST_EN
      if (hit && dcnt_q[idx - 1'b1] != 8'hFF) dcnt_d[idx - 1'b1] = dcnt_q[idx - 1'b1] + 8'd1;
`endif
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      hc_q        <= '{default: '0};
      m_q         <= '{default: '0};
      acc_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
`ifdef HUFF_DEC_HIST_EN
      dcnt_q      <= '{default: '0};
`endif
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      err_q       <= err_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
`ifdef HUFF_DEC_HIST_EN
      dcnt_q      <= dcnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed checks of table load, decoding, flush, error and reset behaviour
module tb_huffman_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   q_sym[$];
  int   q_pos[$];
  int   nsv;
  huffman_if bus ();
`ifdef HUFF_DEC_HIST_EN
  logic [7:0] DCNT1, DCNT2, DCNT3, DCNT4, DCNT5, DCNT6;
`endif
  huffman_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef HUFF_DEC_HIST_EN
    ,
    .DCNT1 (DCNT1),
    .DCNT2 (DCNT2),
    .DCNT3 (DCNT3),
    .DCNT4 (DCNT4),
    .DCNT5 (DCNT5),
    .DCNT6 (DCNT6)
`endif
  );
  always #5 clk = ~clk;
  localparam logic [47:0] T_HC = 48'h00_02_06_0E_1E_1F;
  localparam logic [47:0] T_M  = 48'h01_03_07_0F_1F_1F;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int qs(input int k);
    return k < q_sym.size() ? q_sym[k] : -1;
  endfunction
  function automatic int qp(input int k);
    return k < q_pos.size() ? q_pos[k] : -1;
  endfunction
  task automatic load(input logic [47:0] hc, input logic [47:0] m, input logic bv);
    {bus.HC1, bus.HC2, bus.HC3, bus.HC4, bus.HC5, bus.HC6} = hc;
    {bus.M1, bus.M2, bus.M3, bus.M4, bus.M5, bus.M6} = m;
    bus.code_valid = 1'b1;
    bus.bit_valid  = bv;
    bus.bit_in     = 1'b1;
    step();
    bus.code_valid = 1'b0;
    bus.bit_valid  = 1'b0;
  endtask
  task automatic feed(input logic [15:0] bits, input int n);
    q_sym.delete();
    q_pos.delete();
    for (int i = 0; i < n; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = bits[n-1-i];
      step();
      if (bus.sym_valid) begin
        q_sym.push_back(int'(bus.sym));
        q_pos.push_back(i);
      end
    end
    bus.bit_valid = 1'b0;
  endtask
  task automatic do_flush(input logic bv);
    bus.flush     = 1'b1;
    bus.bit_valid = bv;
    bus.bit_in    = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.bit_valid = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.code_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    {bus.HC1, bus.HC2, bus.HC3, bus.HC4, bus.HC5, bus.HC6} = '0;
    {bus.M1, bus.M2, bus.M3, bus.M4, bus.M5, bus.M6} = '0;
    #3;
    chk("rst_bit_ready", bus.bit_ready, 0);
    chk("rst_sym_valid", bus.sym_valid, 0);
    chk("rst_sym", bus.sym, 0);
    chk("rst_err", bus.err, 0);
    step();
    step();
    reset = 1'b1;
    step();
    // 1: bits before any table load are ignored
    feed(16'b10, 2);
    chk("t1_pre_nsym", q_sym.size(), 0);
    chk("t1_pre_ready", bus.bit_ready, 0);
    load(T_HC, T_M, 1'b0);
    chk("t1_ready", bus.bit_ready, 1);
    feed(16'b0, 1);
    chk("t1_nsym", q_sym.size(), 1);
    chk("t1_sym", qs(0), 1);
    chk("t1_pos", qp(0), 0);
    step();
    chk("t1_pulse_end", bus.sym_valid, 0);
    chk("t1_sym_held", bus.sym, 1);
    // 2: back-to-back stream 110 | 11111 | 10
    feed(16'b1101111110, 10);
    chk("t2_nsym", q_sym.size(), 3);
    chk("t2_sym0", qs(0), 3);
    chk("t2_pos0", qp(0), 2);
    chk("t2_sym1", qs(1), 6);
    chk("t2_pos1", qp(1), 7);
    chk("t2_sym2", qs(2), 2);
    chk("t2_pos2", qp(2), 9);
    // 3: flush drops a partial code and a coincident bit
    feed(16'b11, 2);
    chk("t3_partial_nsym", q_sym.size(), 0);
    do_flush(1'b1);
    chk("t3_flush_sv", bus.sym_valid, 0);
    chk("t3_flush_ready", bus.bit_ready, 1);
    feed(16'b0, 1);
    chk("t3_nsym", q_sym.size(), 1);
    chk("t3_sym", qs(0), 1);
    // 4: 8-bit codes, overflow into ERR
    load(48'hFF_FF_FF_FF_FF_FF & 48'h01_02_03_04_05_06, 48'hFF_FF_FF_FF_FF_FF, 1'b0);
    feed(16'hFF, 8);
    chk("t4_err_nsym", q_sym.size(), 0);
    chk("t4_err", bus.err, 1);
    chk("t4_err_ready", bus.bit_ready, 0);
    feed(16'b1, 1);
    chk("t4_err_sticky", bus.err, 1);
    do_flush(1'b0);
    chk("t4_flush_err", bus.err, 0);
    chk("t4_flush_ready", bus.bit_ready, 1);
    feed(16'h01, 8);
    chk("t4_nsym", q_sym.size(), 1);
    chk("t4_sym", qs(0), 1);
    chk("t4_pos", qp(0), 7);
    // 5: load mid-code with a coincident bit
    load(T_HC, T_M, 1'b0);
    feed(16'b11, 2);
    load(T_HC, T_M, 1'b1);
    chk("t5_load_sv", bus.sym_valid, 0);
    feed(16'b0, 1);
    chk("t5_nsym", q_sym.size(), 1);
    chk("t5_sym", qs(0), 1);
    // mask-0 entry is skipped; among several matches the lowest index wins
    load(48'h0, 48'h00_01_01_01_01_01, 1'b0);
    feed(16'b0, 1);
    chk("tm_nsym", q_sym.size(), 1);
    chk("tm_sym", qs(0), 2);
    // 6: long run of symbol 1, then async reset mid-stream
    load(T_HC, T_M, 1'b0);
    nsv = 0;
    bus.bit_in = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.bit_valid = 1'b1;
      step();
      if (bus.sym_valid && bus.sym == 3'd1) nsv++;
    end
    chk("t6_count", nsv, 300);
`ifdef HUFF_DEC_HIST_EN
    chk("t6_dcnt1", DCNT1, 8'hFF);
    chk("t6_dcnt2", DCNT2, 0);
    chk("t6_dcnt3", DCNT3, 0);
    chk("t6_dcnt4", DCNT4, 0);
    chk("t6_dcnt5", DCNT5, 0);
    chk("t6_dcnt6", DCNT6, 0);
`endif
    chk("t6_pre_sv", bus.sym_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_arst_ready", bus.bit_ready, 0);
    chk("t6_arst_sv", bus.sym_valid, 0);
    chk("t6_arst_sym", bus.sym, 0);
    chk("t6_arst_err", bus.err, 0);
`ifdef HUFF_DEC_HIST_EN
    chk("t6_arst_dcnt1", DCNT1, 0);
`endif
    bus.bit_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
